// File: rtl/icache_dm_pkg.sv
// Shared types and default geometry for the direct-mapped I-cache.
// Address split: | tag | idx | off | 2'b00 |
package icache_dm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    FILL_DONE
  } icache_state_t;

  localparam int LINES_DEF      = 16;
  localparam int LINE_WORDS_DEF = 4;
  localparam int OFF_W_DEF      = $clog2(LINE_WORDS_DEF);
  localparam int IDX_W_DEF      = $clog2(LINES_DEF);
  localparam int TAG_W_DEF      = 30 - OFF_W_DEF - IDX_W_DEF;

endpackage

// File: rtl/icache_dm_if.sv
// Fetch port and single-word instruction bus seen by the I-cache.
// slave = cache side, master = core + bus side.
interface icache_dm_if;

  logic        instr_req;
  logic [31:0] instr_addr;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        flush;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;

  modport slave (
    input  instr_req, instr_addr, flush,
    input  ibus_ack, ibus_rdata,
    output instruction, instr_valid,
    output ibus_req, ibus_addr
  );

  modport master (
    output instr_req, instr_addr, flush,
    output ibus_ack, ibus_rdata,
    input  instruction, instr_valid,
    input  ibus_req, ibus_addr
  );

endinterface

// File: rtl/icache_array.sv
// Tag/valid/data storage: one async read port, one write port.
// Only valid bits are reset; flush-all wins over a same-edge set.
module icache_array
  import icache_dm_pkg::*;
#(
  parameter int LINES      = LINES_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  localparam int OW = $clog2(LINE_WORDS),
  localparam int IW = $clog2(LINES),
  localparam int TW = 30 - OW - IW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_flush,
  input  logic [IW-1:0] i_rd_idx,
  input  logic [OW-1:0] i_rd_off,
  output logic          o_rd_valid,
  output logic [TW-1:0] o_rd_tag,
  output logic [31:0]   o_rd_data,
  input  logic          i_we,
  input  logic [IW-1:0] i_wr_idx,
  input  logic [OW-1:0] i_wr_off,
  input  logic [31:0]   i_wr_data,
  input  logic          i_tag_we,
  input  logic [TW-1:0] i_wr_tag,
  input  logic          i_set_valid
);

  logic [31:0]    r_data [LINES][LINE_WORDS];
  logic [TW-1:0]  r_tag  [LINES];
  logic [LINES-1:0] r_valid;

  always_ff @(posedge clk) begin
    if (i_we)
      r_data[i_wr_idx][i_wr_off] <= i_wr_data;
    if (i_tag_we)
      r_tag[i_wr_idx] <= i_wr_tag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_valid <= '0;
    else if (i_flush)
      r_valid <= '0;
    else if (i_set_valid)
      r_valid[i_wr_idx] <= 1'b1;
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx][i_rd_off];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only I-cache: 0-latency hits, word-by-word refill.
// A flush during refill lets the bus transfer finish but leaves the line invalid.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int LINES      = LINES_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  icache_dm_if.slave  bus
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - OW - IW;

  icache_state_t r_state;
  icache_state_t w_next;
  logic [OW-1:0]   r_cnt;
  logic [29-OW:0]  r_line;
  logic            r_cancel;

  logic [OW-1:0] w_off;
  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic          w_rd_valid;
  logic [TW-1:0] w_rd_tag;
  logic [31:0]   w_rd_data;
  logic          w_hit;
  logic          w_miss;
  logic          w_ack;
  logic          w_last;
  logic          w_unused;

  assign w_off = bus.instr_addr[2+OW-1:2];
  assign w_idx = bus.instr_addr[2+OW+IW-1:2+OW];
  assign w_tag = bus.instr_addr[31:2+OW+IW];
  assign w_unused = &{1'b0, bus.instr_addr[1:0]};

  assign w_hit  = (r_state == IDLE) & bus.instr_req
                & w_rd_valid & (w_rd_tag == w_tag);
  assign w_miss = (r_state == IDLE) & bus.instr_req & ~w_hit;
  assign w_ack  = (r_state == REFILL) & bus.ibus_ack;
  assign w_last = w_ack & (r_cnt == '1);

  icache_array #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (bus.flush),
    .i_rd_idx    (w_idx),
    .i_rd_off    (w_off),
    .o_rd_valid  (w_rd_valid),
    .o_rd_tag    (w_rd_tag),
    .o_rd_data   (w_rd_data),
    .i_we        (w_ack),
    .i_wr_idx    (r_line[IW-1:0]),
    .i_wr_off    (r_cnt),
    .i_wr_data   (bus.ibus_rdata),
    .i_tag_we    (w_last),
    .i_wr_tag    (r_line[29-OW:IW]),
    .i_set_valid (w_last & ~r_cancel)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_line   <= '0;
      r_cancel <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_miss) begin
        r_line   <= bus.instr_addr[31:2+OW];
        r_cnt    <= '0;
        r_cancel <= 1'b0;
      end else begin
        if (w_ack)
          r_cnt <= r_cnt + 1'b1;
        if (bus.flush && r_state == REFILL)
          r_cancel <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    bus.ibus_req    = 1'b0;
    bus.ibus_addr   = '0;
    bus.instr_valid = w_hit;
    bus.instruction = w_hit ? w_rd_data : '0;
    unique case (r_state)
      IDLE: begin
        if (w_miss)
          w_next = REFILL;
      end
      REFILL: begin
        bus.ibus_req  = 1'b1;
        bus.ibus_addr = {r_line, r_cnt, 2'b00};
        if (w_last)
          w_next = FILL_DONE;
      end
      FILL_DONE: w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: refill sequences plus a lookup table.
// Bus model answers each request after a chosen number of wait cycles.
module tb_icache_dm;

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  icache_dm_if bus_if ();

  icache_dm dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_if.slave)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t tbl [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.instr_req = 1'b0;
    bus_if.flush     = 1'b0;
    step();
  endtask

  task automatic lookup(input string nm, input logic req,
                        input logic [31:0] a, input logic ev,
                        input logic [31:0] ei);
    bus_if.instr_req  = req;
    bus_if.instr_addr = a;
    #1;
    chk({nm, "_valid"}, bus_if.instr_valid, ev);
    chk({nm, "_instr"}, bus_if.instruction, ei);
    chk({nm, "_nobus"}, bus_if.ibus_req, 1'b0);
  endtask

  // fl: 0 none, 1..3 flush in cycle after that ack, 4 flush with final ack
  task automatic run_fill(input logic [31:0] a, input logic [31:0] d0,
                          input int lat, input int fl,
                          input logic exp_hit);
    logic [31:0] base;
    logic [31:0] ew;
    base = a & 32'hFFFF_FFF0;
    bus_if.instr_req  = 1'b1;
    bus_if.instr_addr = a;
    #1;
    chk("miss_valid", bus_if.instr_valid, 1'b0);
    chk("miss_nobus", bus_if.ibus_req, 1'b0);
    step();
    bus_if.instr_addr = a ^ 32'h0000_1000;
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k <= lat; k++) begin
        bus_if.ibus_ack   = (k == lat);
        bus_if.ibus_rdata = d0 + w;
        bus_if.flush = (fl > 0 && fl < 4 && w == fl && k == 0) ||
                       (fl == 4 && w == 3 && k == lat);
        #1;
        chk("rf_req", bus_if.ibus_req, 1'b1);
        chk("rf_addr", bus_if.ibus_addr, base + 32'(4 * w));
        chk("rf_valid", bus_if.instr_valid, 1'b0);
        step();
      end
    end
    bus_if.ibus_ack   = 1'b0;
    bus_if.flush      = 1'b0;
    bus_if.instr_addr = a;
    #1;
    chk("fd_valid", bus_if.instr_valid, 1'b0);
    chk("fd_nobus", bus_if.ibus_req, 1'b0);
    step();
    ew = exp_hit ? d0 + 32'(a[3:2]) : 32'h0;
    chk("relook_valid", bus_if.instr_valid, exp_hit);
    chk("relook_instr", bus_if.instruction, ew);
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    tbl[0] = '{1'b1, 32'h0000_004C, 1'b1, 32'hA3};
    tbl[1] = '{1'b1, 32'h0000_0044, 1'b1, 32'hA1};
    tbl[2] = '{1'b1, 32'h0000_0088, 1'b1, 32'hB2};
    tbl[3] = '{1'b0, 32'h0000_0040, 1'b0, 32'h00};
    tbl[4] = '{1'b1, 32'h0000_0140, 1'b0, 32'h00};
    tbl[5] = '{1'b1, 32'h0000_0050, 1'b0, 32'h00};
    tbl[6] = '{1'b1, 32'h0000_008F, 1'b1, 32'hB3};
    tbl[7] = '{1'b1, 32'h0000_0042, 1'b1, 32'hA0};

    rst_n             = 1'b0;
    bus_if.instr_req  = 1'b1;
    bus_if.instr_addr = 32'h40;
    bus_if.flush      = 1'b0;
    bus_if.ibus_ack   = 1'b0;
    bus_if.ibus_rdata = '0;
    #3;
    chk("rst_valid", bus_if.instr_valid, 1'b0);
    chk("rst_instr", bus_if.instruction, 32'h0);
    chk("rst_breq", bus_if.ibus_req, 1'b0);
    chk("rst_baddr", bus_if.ibus_addr, 32'h0);
    bus_if.instr_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_fill(32'h40, 32'hA0, 1, 0, 1'b1);
    idle();
    run_fill(32'h88, 32'hB0, 0, 0, 1'b1);
    idle();

    for (int i = 0; i < 8; i++) begin
      lookup($sformatf("tbl%0d", i), tbl[i].req, tbl[i].addr,
             tbl[i].exp_valid, tbl[i].exp_instr);
      idle();
    end

    run_fill(32'h140, 32'hC0, 1, 0, 1'b1);
    idle();
    lookup("conf_80", 1'b1, 32'h84, 1'b1, 32'hB1);
    idle();
    run_fill(32'h4C, 32'hA0, 1, 0, 1'b1);
    idle();

    bus_if.flush = 1'b1;
    lookup("fl_hit", 1'b1, 32'h44, 1'b1, 32'hA1);
    bus_if.instr_req = 1'b0;
    step();
    bus_if.flush = 1'b0;
    lookup("fl_after40", 1'b1, 32'h44, 1'b0, 32'h0);
    lookup("fl_after80", 1'b1, 32'h8C, 1'b0, 32'h0);
    idle();

    run_fill(32'h200, 32'hD0, 1, 2, 1'b0);
    run_fill(32'h204, 32'hD0, 1, 0, 1'b1);
    idle();
    run_fill(32'h210, 32'hE0, 0, 4, 1'b0);
    idle();
    lookup("fl_last", 1'b1, 32'h21C, 1'b0, 32'h0);
    idle();

    run_fill(32'h308, 32'hF0, 5, 0, 1'b1);
    idle();

    bus_if.instr_req  = 1'b1;
    bus_if.instr_addr = 32'h40;
    step();
    chk("ar_req_pre", bus_if.ibus_req, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_req", bus_if.ibus_req, 1'b0);
    chk("ar_addr", bus_if.ibus_addr, 32'h0);
    bus_if.instr_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    lookup("ar_300", 1'b1, 32'h308, 1'b0, 32'h0);
    idle();
    run_fill(32'h40, 32'hA4, 1, 0, 1'b1);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
